// File: rtl/bp_be_stride_pf_issue_pkg.sv
// bp_be_stride_pf_issue_pkg
//   Shared types and defaults for the stride prefetch issue block.
//   - vaddr_width_gp / dcache_block_width_gp : default processor config values
//   - bp_be_stride_pf_state_e                : issue FSM states
//   - block_offset_width()                   : byte-offset width of a D$ block
//   Optional feature macro used by the block: BP_BE_STRIDE_PF_LINE_DEDUP_EN.
package bp_be_stride_pf_issue_pkg;

    localparam int unsigned vaddr_width_gp        = 39;
    localparam int unsigned dcache_block_width_gp = 512;

    typedef enum logic [1:0] {
        e_idle     = 2'd0,
        e_discover = 2'd1,
        e_issue    = 2'd2
    } bp_be_stride_pf_state_e;

    // Block width is given in bits; the offset covers its bytes.
    function automatic int unsigned block_offset_width(input int unsigned block_width_bits);
        return $clog2(block_width_bits / 8);
    endfunction

endpackage

// File: rtl/bp_be_stride_pf_issue_counter.sv
// bp_be_stride_pf_issue_counter
//   Clear/up counter saturating at max_val_p (clear_up counter semantics).
//   Ports:
//     clk_i, reset_i : clock, asynchronous active-high reset
//     clear_i        : synchronous clear, wins over up_i
//     up_i           : increment by one (held at max_val_p once reached)
//     count_o        : current count
module bp_be_stride_pf_issue_counter #(
    parameter int unsigned max_val_p = 4,
    parameter int unsigned width_p   = $clog2(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (up_i && (count_q < width_p'(max_val_p))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_be_stride_pf_issue.sv
// bp_be_stride_pf_issue
//   Consumes stride predictions and discovery start/confirm events. After a
//   confirm it walks ahead of the striding load and presents pf_depth_p
//   prefetch virtual addresses on a valid/yumi handshake.
//   Ports:
//     clk_i, reset_i        : clock, asynchronous active-high reset
//     flush_i               : abort all tracking, return to e_idle
//     stride_v_i            : qualifies stride_i, pc_i, eff_addr_i, start/confirm
//     stride_i              : signed byte stride
//     pc_i, eff_addr_i      : PC and effective address of the striding load
//     start_discovery_i     : begin tracking a new sequence
//     confirm_discovery_i   : sequence confirmed, begin issuing
//     pf_v_o, pf_vaddr_o    : registered prefetch request
//     pf_yumi_i             : request consumed this cycle
//     busy_o                : registered, high whenever not in e_idle
//   Macro BP_BE_STRIDE_PF_LINE_DEDUP_EN: skip candidates falling in the same
//   D$ line as the last issued request (skips still count toward the depth).
module bp_be_stride_pf_issue
    import bp_be_stride_pf_issue_pkg::*;
#(
    parameter int unsigned vaddr_width_p        = vaddr_width_gp,
    parameter int unsigned dcache_block_width_p = dcache_block_width_gp,
    parameter int unsigned stride_width_p       = 8,
    parameter int unsigned pf_depth_p           = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     stride_v_i,
    input  logic [stride_width_p-1:0] stride_i,
    input  logic [vaddr_width_p-1:0] pc_i,
    input  logic [vaddr_width_p-1:0] eff_addr_i,
    input  logic                     start_discovery_i,
    input  logic                     confirm_discovery_i,
    output logic                     pf_v_o,
    output logic [vaddr_width_p-1:0] pf_vaddr_o,
    input  logic                     pf_yumi_i,
    output logic                     busy_o
);

    localparam int unsigned block_offset_lp = block_offset_width(dcache_block_width_p);
    localparam int unsigned count_width_lp  = $clog2(pf_depth_p + 1);

    if (pf_depth_p < 1) begin : g_bad_depth
        $error("pf_depth_p must be at least 1");
    end
    if (stride_width_p >= vaddr_width_p) begin : g_bad_stride
        $error("stride_width_p must be narrower than vaddr_width_p");
    end
    if (block_offset_lp >= vaddr_width_p) begin : g_bad_block
        $error("D$ block offset must be narrower than vaddr_width_p");
    end

    bp_be_stride_pf_state_e state_q, state_d;

    logic [vaddr_width_p-1:0] pc_q, pc_d;
    logic [vaddr_width_p-1:0] stride_q, stride_d;
    logic [vaddr_width_p-1:0] next_addr_q, next_addr_d;
    logic                     pf_v_q, pf_v_d;
    logic                     busy_q, busy_d;

    logic [vaddr_width_p-1:0] stride_sext;
    logic [count_width_lp-1:0] count;
    logic start, confirm, pc_match;
    logic yumi_fire, skip, advance, last;
    logic line_hit;

    assign start       = stride_v_i & start_discovery_i;
    assign confirm     = stride_v_i & confirm_discovery_i;
    assign pc_match    = (pc_i == pc_q);
    assign stride_sext = {{(vaddr_width_p - stride_width_p){stride_i[stride_width_p-1]}}, stride_i};

    // pf_v_q is only ever high in e_issue, so it alone qualifies the handshake.
    assign yumi_fire = pf_v_q & pf_yumi_i;
    assign advance   = yumi_fire | skip;
    assign last      = advance & (count == count_width_lp'(pf_depth_p - 1));

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        stride_d    = stride_q;
        next_addr_d = next_addr_q;
        if (flush_i) begin
            state_d = e_idle;
        end else if (start) begin
            // Discovery base is re-supplied by the confirm, so only pc/stride are kept.
            state_d  = e_discover;
            pc_d     = pc_i;
            stride_d = stride_sext;
        end else begin
            case (state_q)
                e_discover: begin
                    if (confirm) begin
                        stride_d    = stride_sext;
                        next_addr_d = eff_addr_i + stride_sext;
                        state_d     = (stride_i == '0) ? e_idle : e_issue;
                    end else if (stride_v_i && pc_match) begin
                        stride_d = stride_sext;
                    end
                end
                e_issue: begin
                    if (advance) begin
                        next_addr_d = next_addr_q + stride_q;
                        if (last) begin
                            state_d = e_idle;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BP_BE_STRIDE_PF_LINE_DEDUP_EN
    localparam int unsigned line_width_lp = vaddr_width_p - block_offset_lp;

    logic [line_width_lp-1:0] last_line_q, last_line_d;
    logic                     last_line_v_q, last_line_v_d;

    // In e_issue a low pf_v_q can only mean the presented candidate was a repeat.
    assign skip = (state_q == e_issue) & ~pf_v_q;

    always_comb begin
        last_line_d   = last_line_q;
        last_line_v_d = last_line_v_q;
        if (flush_i || start) begin
            last_line_d   = '0;
            last_line_v_d = 1'b0;
        end else if (yumi_fire) begin
            last_line_d   = next_addr_q[vaddr_width_p-1:block_offset_lp];
            last_line_v_d = 1'b1;
        end
    end

    // Look ahead at the next candidate so pf_v_o stays registered.
    assign line_hit = last_line_v_d
                    & (next_addr_d[vaddr_width_p-1:block_offset_lp] == last_line_d);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_line_q   <= '0;
            last_line_v_q <= 1'b0;
        end else begin
            last_line_q   <= last_line_d;
            last_line_v_q <= last_line_v_d;
        end
    end
`else
    assign skip     = 1'b0;
    assign line_hit = 1'b0;
`endif

    assign pf_v_d = (state_d == e_issue) & ~line_hit;
    assign busy_d = (state_d != e_idle);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_idle;
            pc_q        <= '0;
            stride_q    <= '0;
            next_addr_q <= '0;
            pf_v_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            stride_q    <= stride_d;
            next_addr_q <= next_addr_d;
            pf_v_q      <= pf_v_d;
            busy_q      <= busy_d;
        end
    end

    bp_be_stride_pf_issue_counter #(
        .max_val_p (pf_depth_p),
        .width_p   (count_width_lp)
    ) u_count (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (flush_i | start),
        .up_i    (advance),
        .count_o (count)
    );

    assign pf_v_o     = pf_v_q;
    assign pf_vaddr_o = next_addr_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_bp_be_stride_pf_issue.sv
module tb_bp_be_stride_pf_issue;

    localparam int unsigned W   = 39;
    localparam int unsigned SW  = 8;
    localparam int unsigned D   = 4;
    localparam int unsigned BLK = 512;
    localparam int unsigned OFF = 6;  // 64-byte lines

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          stride_v = 1'b0;
    logic [SW-1:0] stride = '0;
    logic [W-1:0]  pc = '0;
    logic [W-1:0]  eff = '0;
    logic          start_d = 1'b0;
    logic          confirm_d = 1'b0;
    logic          yumi = 1'b0;
    logic          pf_v;
    logic [W-1:0]  pf_vaddr;
    logic          busy;

    always #5 clk = ~clk;

    bp_be_stride_pf_issue #(
        .vaddr_width_p        (W),
        .dcache_block_width_p (BLK),
        .stride_width_p       (SW),
        .pf_depth_p           (D)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .flush_i             (flush),
        .stride_v_i          (stride_v),
        .stride_i            (stride),
        .pc_i                (pc),
        .eff_addr_i          (eff),
        .start_discovery_i   (start_d),
        .confirm_discovery_i (confirm_d),
        .pf_v_o              (pf_v),
        .pf_vaddr_o          (pf_vaddr),
        .pf_yumi_i           (yumi),
        .busy_o              (busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [SW-1:0]         stride;
        logic [W-1:0]          conf_addr;
        logic [D-1:0][W-1:0]   exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        stride_v  = 1'b0;
        start_d   = 1'b0;
        confirm_d = 1'b0;
        yumi      = 1'b0;
        flush     = 1'b0;
    endtask

    function automatic bit dedup_on();
`ifdef BP_BE_STRIDE_PF_LINE_DEDUP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // k-th address after base, modulo 2^W, with a signed byte stride.
    function automatic logic [W-1:0] cand(input logic [W-1:0] base, input logic [SW-1:0] s,
                                          input int k);
        longint sd;
        sd = longint'($signed(s));
        return W'(longint'(base) + longint'(k) * sd);
    endfunction

    // Start one cycle, confirm the next; outputs afterwards reflect the confirm.
    task automatic begin_burst(input logic [W-1:0] pcv, input logic [SW-1:0] s,
                               input logic [W-1:0] conf_a);
        stride_v = 1'b1; start_d = 1'b1; confirm_d = 1'b0;
        pc = pcv; stride = s; eff = cand(conf_a, s, -1);
        tick();
        start_d = 1'b0; confirm_d = 1'b1; eff = conf_a;
        tick();
        idle_in();
    endtask

    initial begin
        logic [W-1:0] q [$];
        logic [W-1:0] pcv, conf_a, ln, last_ln;
        logic [SW-1:0] s;
        bit have_ln, emit;
        int cyc;

        vecs[0] = '{stride: 8'h40, conf_addr: 39'h1080,
                    exp: {39'h1180, 39'h1140, 39'h1100, 39'h10C0}};
        vecs[1] = '{stride: 8'hF0, conf_addr: 39'h8,
                    exp: {39'h7F_FFFF_FFC8, 39'h7F_FFFF_FFD8, 39'h7F_FFFF_FFE8, 39'h7F_FFFF_FFF8}};
        vecs[2] = '{stride: 8'h7F, conf_addr: 39'h0,
                    exp: {39'h1FC, 39'h17D, 39'hFE, 39'h7F}};
        vecs[3] = '{stride: 8'h80, conf_addr: 39'h100,
                    exp: {39'h7F_FFFF_FF00, 39'h7F_FFFF_FF80, 39'h0, 39'h80}};
        vecs[4] = '{stride: 8'h08, conf_addr: 39'h2000,
                    exp: {39'h2020, 39'h2018, 39'h2010, 39'h2008}};

        // Reset state
        tick(); tick();
        chk("reset_pf_v", 64'(pf_v), 64'd0);
        chk("reset_vaddr", 64'(pf_vaddr), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();

        // Table: bursts with yumi whenever valid
        for (int i = 0; i < 5; i++) begin
            begin_burst(39'h400 + W'(i), vecs[i].stride, vecs[i].conf_addr);
            have_ln = 1'b0;
            last_ln = '0;
            for (int k = 0; k < int'(D); k++) begin
                ln   = vecs[i].exp[k] >> OFF;
                emit = !(dedup_on() && have_ln && ln == last_ln);
                if (emit) begin
                    have_ln = 1'b1;
                    last_ln = ln;
                    chk($sformatf("vec%0d_v%0d", i, k), 64'(pf_v), 64'd1);
                    chk($sformatf("vec%0d_addr%0d", i, k), 64'(pf_vaddr), 64'(vecs[i].exp[k]));
                end else begin
                    chk($sformatf("vec%0d_skip%0d", i, k), 64'(pf_v), 64'd0);
                end
                chk($sformatf("vec%0d_busy%0d", i, k), 64'(busy), 64'd1);
                yumi = pf_v;
                tick();
                yumi = 1'b0;
            end
            chk($sformatf("vec%0d_end_v", i), 64'(pf_v), 64'd0);
            chk($sformatf("vec%0d_end_busy", i), 64'(busy), 64'd0);
        end

        // Backpressure: address holds, count moves only on yumi
        begin_burst(39'h500, 8'h40, 39'h3000);
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_v", 64'(pf_v), 64'd1);
            chk("bp_hold_addr", 64'(pf_vaddr), 64'h3040);
            tick();
        end
        yumi = 1'b1; tick(); yumi = 1'b0;
        chk("bp_addr2", 64'(pf_vaddr), 64'h3080);
        tick();
        chk("bp_addr2_hold", 64'(pf_vaddr), 64'h3080);
        yumi = 1'b1; tick();
        chk("bp_addr3", 64'(pf_vaddr), 64'h30C0);
        tick();
        chk("bp_addr4", 64'(pf_vaddr), 64'h3100);
        chk("bp_busy_before_last", 64'(busy), 64'd1);
        tick(); yumi = 1'b0;
        chk("bp_done_v", 64'(pf_v), 64'd0);
        chk("bp_done_busy", 64'(busy), 64'd0);

        // Start and confirm together: start wins, stays in discovery
        stride_v = 1'b1; start_d = 1'b1; confirm_d = 1'b1;
        pc = 39'h600; stride = 8'h40; eff = 39'h5000;
        tick();
        chk("sc_v", 64'(pf_v), 64'd0);
        chk("sc_busy", 64'(busy), 64'd1);
        start_d = 1'b0;
        tick();
        idle_in();
        chk("sc_confirm_v", 64'(pf_v), 64'd1);
        chk("sc_confirm_addr", 64'(pf_vaddr), 64'h5040);

        // Flush mid-burst, then a lone confirm in idle is ignored
        yumi = 1'b1; tick(); yumi = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_v", 64'(pf_v), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        stride_v = 1'b1; confirm_d = 1'b1; eff = 39'h5000;
        tick();
        idle_in();
        chk("idle_confirm_v", 64'(pf_v), 64'd0);
        chk("idle_confirm_busy", 64'(busy), 64'd0);

        // Zero-stride confirm issues nothing
        begin_burst(39'h700, 8'h00, 39'h6000);
        chk("zero_v", 64'(pf_v), 64'd0);
        chk("zero_busy", 64'(busy), 64'd0);

        // Start during issue with yumi: consumed, then tracking restarts
        begin_burst(39'h800, 8'h40, 39'h7000);
        yumi = 1'b1; stride_v = 1'b1; start_d = 1'b1;
        pc = 39'h900; stride = 8'h10; eff = 39'h8FF0;
        tick();
        chk("restart_v", 64'(pf_v), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        yumi = 1'b0; start_d = 1'b0; confirm_d = 1'b1; eff = 39'h9000;
        tick();
        idle_in();
        chk("restart_addr", 64'(pf_vaddr), 64'h9010);
        chk("restart_v2", 64'(pf_v), 64'd1);

        // Asynchronous reset mid-burst
        yumi = 1'b1; tick(); yumi = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("areset_v", 64'(pf_v), 64'd0);
        chk("areset_busy", 64'(busy), 64'd0);
        chk("areset_addr", 64'(pf_vaddr), 64'd0);
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("areset_after_v", 64'(pf_v), 64'd0);
        chk("areset_after_busy", 64'(busy), 64'd0);

        // Random bursts against an address-sequence model
        for (int b = 0; b < 40; b++) begin
            pcv    = W'({$urandom, $urandom});
            s      = ($urandom_range(0, 7) == 0) ? 8'h00 : SW'($urandom);
            conf_a = W'({$urandom, $urandom});
            stride_v = 1'b1; start_d = 1'b1; pc = pcv; stride = SW'($urandom);
            eff = W'({$urandom, $urandom});
            tick();
            start_d = 1'b0;
            for (int u = 0; u < int'($urandom_range(0, 3)); u++) begin
                stride_v = $urandom_range(0, 1) == 1;
                pc       = ($urandom_range(0, 1) == 1) ? pcv : W'({$urandom, $urandom});
                stride   = SW'($urandom);
                eff      = W'({$urandom, $urandom});
                tick();
            end
            stride_v = 1'b1; confirm_d = 1'b1; pc = pcv; stride = s; eff = conf_a;
            tick();
            idle_in();

            q.delete();
            have_ln = 1'b0;
            last_ln = '0;
            if (s != 8'h00) begin
                for (int k = 1; k <= int'(D); k++) begin
                    ln = cand(conf_a, s, k) >> OFF;
                    if (!(dedup_on() && have_ln && ln == last_ln)) begin
                        q.push_back(cand(conf_a, s, k));
                        have_ln = 1'b1;
                        last_ln = ln;
                    end
                end
            end

            cyc = 0;
            while (cyc < 100 && (busy || pf_v)) begin
                if (pf_v) begin
                    chk("rnd_pending", 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        chk("rnd_addr", 64'(pf_vaddr), 64'(q[0]));
                    end
                end
                yumi = pf_v && ($urandom_range(0, 2) != 0);
                if (yumi && q.size() != 0) begin
                    void'(q.pop_front());
                end
                // Stride-side traffic while issuing must be ignored
                stride_v  = $urandom_range(0, 1) == 1;
                confirm_d = $urandom_range(0, 3) == 0;
                pc        = ($urandom_range(0, 1) == 1) ? pcv : W'({$urandom, $urandom});
                stride    = SW'($urandom);
                eff       = W'({$urandom, $urandom});
                tick();
                cyc++;
            end
            idle_in();
            chk("rnd_timeout", 64'(cyc < 100), 64'd1);
            chk("rnd_drained", 64'(q.size()), 64'd0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
